// File: rtl/timer2_postscaled_pkg.sv
// Shared peripheral constants for the timer 2 block: T2CON field layout and
// prescaler encodings, also consumed by the SFR address decode.
package timer2_postscaled_pkg;

  localparam int T2CON_W    = 7;
  localparam int TOUTPS_MSB = 6;
  localparam int TOUTPS_LSB = 3;
  localparam int TMR2ON_BIT = 2;
  localparam int T2CKPS_MSB = 1;
  localparam int T2CKPS_LSB = 0;

  typedef enum logic [1:0] {
    CKPS_DIV1    = 2'b00,
    CKPS_DIV4    = 2'b01,
    CKPS_DIV16   = 2'b10,
    CKPS_DIV16_B = 2'b11
  } t2ckps_e;

  // Field order mirrors the bit positions above (MSB first).
  typedef struct packed {
    logic [3:0] toutps;
    logic       tmr2on;
    logic [1:0] t2ckps;
  } t2con_t;

  // Terminal value of the prescale counter: divide ratio minus one.
  function automatic logic [3:0] prescale_limit(input logic [1:0] ckps);
    logic [3:0] lim;
    case (t2ckps_e'(ckps))
      CKPS_DIV1: lim = 4'd0;
      CKPS_DIV4: lim = 4'd3;
      default:   lim = 4'd15;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/timer2_postscaled_postscaler.sv
// Postscale counter for timer 2: counts match events and emits a one-cycle
// registered pulse when the count reaches TOUTPS.
module tmr2_postscaler
  import timer2_postscaled_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       match,
  input  logic       clear,
  input  logic [3:0] toutps,
  output logic       pulse
);

  logic [3:0] count_q;
  logic       at_limit;

  assign at_limit = (count_q == toutps);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
      pulse   <= 1'b0;
    end else begin
      // Clear dominates: a register write never produces a pulse.
      pulse <= match && !clear && at_limit;
      if (clear) begin
        count_q <= 4'd0;
      end else if (match) begin
        count_q <= at_limit ? 4'd0 : count_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer2_postscaled.sv
// Timer 2: 8-bit period timer with programmable prescaler (/1, /4, /16),
// period register PR2 and 1..16 postscaler driving the interrupt-flag set pulse.
module timer2_postscaled
  import timer2_postscaled_pkg::*;
#(
  parameter logic [7:0] PR2_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt,
  input  logic [7:0] data_in,
  input  logic       tmr2_wr_en,
  input  logic       pr2_wr_en,
  input  logic       t2con_wr_en,
  output logic [7:0] tmr2_out,
  output logic [7:0] pr2_out,
  output logic [6:0] t2con_out,
  output logic       tmr2if_set
);

  logic [7:0] tmr_q;
  logic [7:0] pr_q;
  t2con_t     con_q;
  logic [3:0] pre_q;

  logic       run;
  logic       tick;
  logic       match;
  logic       clear;

  // Any TMR2 or T2CON write suspends counting for that cycle and restarts
  // both the prescaler and the postscaler.
  assign clear = tmr2_wr_en || t2con_wr_en;
  assign run   = cnt && con_q.tmr2on && !clear;
  assign tick  = run && (pre_q == prescale_limit(con_q.t2ckps));
  assign match = tick && (tmr_q == pr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= 8'd0;
      pr_q  <= PR2_RESET;
      con_q <= '0;
      pre_q <= 4'd0;
    end else begin
      if (tmr2_wr_en) begin
        tmr_q <= data_in;
      end else if (tick) begin
        // Wraps naturally through 8'hFF when PR2 was written below TMR2.
        tmr_q <= match ? 8'd0 : tmr_q + 8'd1;
      end

      if (clear) begin
        pre_q <= 4'd0;
      end else if (run) begin
        pre_q <= tick ? 4'd0 : pre_q + 4'd1;
      end

      if (pr2_wr_en) begin
        pr_q <= data_in;
      end
      if (t2con_wr_en) begin
        con_q <= t2con_t'(data_in[T2CON_W-1:0]);
      end
    end
  end

  tmr2_postscaler u_postscaler (
    .clk    (clk),
    .rst    (rst),
    .match  (match),
    .clear  (clear),
    .toutps (con_q.toutps),
    .pulse  (tmr2if_set)
  );

  assign tmr2_out  = tmr_q;
  assign pr2_out   = pr_q;
  assign t2con_out = con_q;

endmodule

// File: tb/tb_timer2_postscaled.sv
// Self-checking bench for timer2_postscaled: event-count reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_timer2_postscaled;

  logic       clk;
  logic       rst;
  logic       cnt;
  logic [7:0] data_in;
  logic       tmr2_wr_en;
  logic       pr2_wr_en;
  logic       t2con_wr_en;
  logic [7:0] tmr2_out;
  logic [7:0] pr2_out;
  logic [6:0] t2con_out;
  logic       tmr2if_set;

  int checks;
  int failures;

  timer2_postscaled #(.PR2_RESET(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt         (cnt),
    .data_in     (data_in),
    .tmr2_wr_en  (tmr2_wr_en),
    .pr2_wr_en   (pr2_wr_en),
    .t2con_wr_en (t2con_wr_en),
    .tmr2_out    (tmr2_out),
    .pr2_out     (pr2_out),
    .t2con_out   (t2con_out),
    .tmr2if_set  (tmr2if_set)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Prescaler and postscaler are modelled as totals of events since the last
  // clear: a tick is every div-th enabled cnt, a pulse every (TOUTPS+1)-th match.
  int m_tmr, m_pr, m_con, m_pre_n, m_match_n;
  bit m_pulse;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int div, ntmr, npre, nmatch, ckps, post;
    bit tick, mt, np;
    if (rst) begin
      m_tmr     <= 0;
      m_pr      <= 255;
      m_con     <= 0;
      m_pre_n   <= 0;
      m_match_n <= 0;
      m_pulse   <= 1'b0;
      m_valid   <= 1'b1;
    end else if (m_valid) begin
      ckps   = m_con % 4;
      div    = (ckps == 0) ? 1 : (ckps == 1) ? 4 : 16;
      post   = (m_con / 8) % 16 + 1;
      npre   = m_pre_n;
      nmatch = m_match_n;
      ntmr   = m_tmr;
      tick   = 1'b0;
      mt     = 1'b0;
      np     = 1'b0;
      if (cnt && ((m_con / 4) % 2 == 1) && !tmr2_wr_en && !t2con_wr_en) begin
        npre = npre + 1;
        tick = (npre % div) == 0;
      end
      if (tick) begin
        if (m_tmr == m_pr) begin
          mt   = 1'b1;
          ntmr = 0;
        end else begin
          ntmr = (m_tmr + 1) % 256;
        end
      end
      if (mt) begin
        nmatch = nmatch + 1;
        np     = (nmatch % post) == 0;
      end
      if (tmr2_wr_en) ntmr = int'(data_in);
      if (tmr2_wr_en || t2con_wr_en) begin
        npre   = 0;
        nmatch = 0;
      end
      m_tmr     <= ntmr;
      m_pre_n   <= npre;
      m_match_n <= nmatch;
      m_pulse   <= np;
      if (pr2_wr_en)   m_pr  <= int'(data_in);
      if (t2con_wr_en) m_con <= int'(data_in) % 128;
    end
  end

  // ---------------- scoreboard compare (every cycle, on the falling edge) ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tmr2",  int'(tmr2_out),   m_tmr);
      chk("model_pr2",   int'(pr2_out),    m_pr);
      chk("model_t2con", int'(t2con_out),  m_con);
      chk("model_pulse", int'(tmr2if_set), int'(m_pulse));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic tw, input logic pw,
                       input logic cw, input logic [7:0] d);
    cnt         = c;
    tmr2_wr_en  = tw;
    pr2_wr_en   = pw;
    t2con_wr_en = cw;
    data_in     = d;
  endtask

  // Stop the timer, load PR2, zero TMR2, then enable with the given T2CON;
  // on return cnt is high and the next step is the first counting cycle.
  task automatic cfg(input logic [7:0] pr, input logic [7:0] con);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00); step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, pr);    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00); step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, con);   step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(); step();
    chk("reset_tmr2",  int'(tmr2_out),   0);
    chk("reset_pr2",   int'(pr2_out),    255);
    chk("reset_t2con", int'(t2con_out),  0);
    chk("reset_pulse", int'(tmr2if_set), 0);
    rst = 1'b0;

    // /1, PR2=3: 0,1,2,3,0 with a pulse every 4 cycles
    cfg(8'd3, 8'h04);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("div1_tmr2",  int'(tmr2_out),   i % 4);
      chk("div1_pulse", int'(tmr2if_set), (i % 4 == 0) ? 1 : 0);
    end

    // /4, PR2=1: advance every 4 cnt cycles, first pulse 8 cycles after enable
    cfg(8'd1, 8'h05);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("div4_tmr2",  int'(tmr2_out),   (i / 4) % 2);
      chk("div4_pulse", int'(tmr2if_set), (i == 8) ? 1 : 0);
    end

    // postscale 16, PR2=0: TMR2 stays 0, one pulse per 16 cycles
    cfg(8'd0, 8'h7C);
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("post16_tmr2",  int'(tmr2_out),   0);
      chk("post16_pulse", int'(tmr2if_set), (i % 16 == 0) ? 1 : 0);
    end

    // TMR2 write colliding with a match at PR2=5, then wrap through 0xFF
    cfg(8'd5, 8'h04);
    for (int i = 1; i <= 5; i++) step();
    chk("wr_pre_tmr2", int'(tmr2_out), 5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wr_tmr2",  int'(tmr2_out),   16);
    chk("wr_pulse", int'(tmr2if_set), 0);
    for (int j = 1; j <= 246; j++) begin
      step();
      if (j == 239) chk("wrap_ff",     int'(tmr2_out),   255);
      if (j == 240) chk("wrap_zero",   int'(tmr2_out),   0);
      if (j == 240) chk("wrap_nopls",  int'(tmr2if_set), 0);
      if (j == 245) chk("wrap_five",   int'(tmr2_out),   5);
      if (j == 246) chk("wrap_match",  int'(tmr2_out),   0);
      if (j == 246) chk("wrap_pulse",  int'(tmr2if_set), 1);
    end

    // reset in the cycle of a match
    cfg(8'd3, 8'h04);
    for (int i = 1; i <= 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstm_tmr2",  int'(tmr2_out),   0);
    chk("rstm_pr2",   int'(pr2_out),    255);
    chk("rstm_t2con", int'(t2con_out),  0);
    chk("rstm_pulse", int'(tmr2if_set), 0);
    step();
    chk("rstm_pulse2", int'(tmr2if_set), 0);

    // TMR2ON cleared at TMR2=7, then resumed at /4
    cfg(8'd20, 8'h04);
    for (int i = 1; i <= 7; i++) step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 10; i++) step();
    chk("off_hold", int'(tmr2_out), 7);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h05);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("resume_tmr2", int'(tmr2_out), (i == 4) ? 8 : 7);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      logic       tw, pw, cw;
      tw = ($urandom_range(0, 99) < 2);
      pw = ($urandom_range(0, 99) < 3);
      cw = ($urandom_range(0, 99) < 2);
      if (cw && !tw && !pw) begin
        d = {1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
             2'($urandom_range(0, 3))};
      end else if ($urandom_range(0, 3) != 0) begin
        d = 8'($urandom_range(0, 12));
      end else begin
        d = 8'($urandom_range(0, 255));
      end
      rst = ($urandom_range(0, 499) == 0);
      drive(($urandom_range(0, 3) != 0), tw, pw, cw, d);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer2_postscaled.md
TIMER2_POSTSCALED -- requirements
Module: timer2_postscaled

Interface
REQ-001 SHALL take parameter PR2_RESET, default 8'hFF: reset value of the period register.
REQ-002 SHALL have port clk, input, 1: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cnt, input, 1: instruction-cycle tick; the block counts only when it is high.
REQ-005 SHALL have port data_in, input, 8: shared register write data.
REQ-006 SHALL have port tmr2_wr_en, input, 1: write data_in to TMR2.
REQ-007 SHALL have port pr2_wr_en, input, 1: write data_in to PR2.
REQ-008 SHALL have port t2con_wr_en, input, 1: write data_in[6:0] to T2CON.
REQ-009 SHALL have port tmr2_out, output, 8: current TMR2 value.
REQ-010 SHALL have port pr2_out, output, 8: current PR2 value.
REQ-011 SHALL have port t2con_out, output, 7: current T2CON value.
REQ-012 SHALL have port tmr2if_set, output, 1: one-cycle interrupt-flag set pulse.

Function
REQ-013 SHALL decode T2CON as follows: [6:3] TOUTPS, giving postscale TOUTPS+1 (1..16); [2] TMR2ON; [1:0] T2CKPS, where 00 is /1, 01 is /4, and 1x is /16.
REQ-014 SHALL hold a 4-bit prescale counter that increments on cnt&&TMR2ON and produces a prescaled tick in the cycle where the counter equals divide-1 and cnt&&TMR2ON holds; the counter then wraps to 0.
REQ-015 SHALL increment TMR2 by 1 on a prescaled tick when TMR2!=PR2, and SHALL load TMR2 with 0 on a prescaled tick when TMR2==PR2 (a match event).
REQ-016 SHALL, on each match event, increment a 4-bit postscale counter; when the postscale counter equals TOUTPS it SHALL wrap to 0 and drive tmr2if_set high for exactly the next cycle (registered output, latency 1 cycle after the matching clock edge).
REQ-017 SHALL, with PR2==0, produce a match on every prescaled tick, with TMR2 held at 0.
REQ-018 SHALL, on a tmr2_wr_en cycle, load TMR2 from data_in and clear both the prescale and postscale counters; the write SHALL win over a simultaneous tick or match, and SHALL generate no match or pulse that cycle.
REQ-019 SHALL, on a t2con_wr_en cycle, clear the prescale and postscale counters; TMR2 SHALL keep its value and SHALL not count that cycle.
REQ-020 SHALL not clear any counter on a pr2_wr_en write; the new PR2 SHALL apply to comparisons from the next cycle.
REQ-021 SHALL, when TMR2ON=0, freeze TMR2, both counters and tmr2if_set (low); register writes SHALL still take effect.
REQ-022 SHALL, if PR2 is written below the current TMR2, let TMR2 count up through 8'hFF, wrap to 0 without a match, and continue to PR2.
REQ-023 SHALL make tmr2_out, pr2_out and t2con_out reflect a write in the cycle after the write edge.

Reset
REQ-024 SHALL, on rst high at a clock edge, set TMR2=0, PR2=PR2_RESET, T2CON=0, both counters to 0 and tmr2if_set=0, overriding every write and count in that cycle.
REQ-025 SHALL, on reset asserted mid-count, produce no tmr2if_set pulse in the following cycle.

Structure
REQ-026 SHALL take its T2CON bit positions and T2CKPS encodings from the shared peripheral constants header, which is also used by the SFR decode.
REQ-027 SHALL implement the postscale counter and pulse generation as one sub-module, tmr2_postscaler (inputs: match, clear, TOUTPS; output: pulse).
REQ-028 SHALL not contain latches or combinational feedback; the RTL size SHALL be within 120-400 lines.

Verification
REQ-029 SHALL cover: T2CON=0x04, PR2=3, cnt held high -> TMR2 runs 0,1,2,3,0,...; tmr2if_set pulses every 4 cycles.
REQ-030 SHALL cover: T2CON=0x05 (/4), PR2=1 -> TMR2 advances every 4 cnt cycles; the first pulse comes 8 cnt cycles after enable.
REQ-031 SHALL cover: T2CON=0x7C (postscale 16), PR2=0 -> exactly one pulse per 16 cnt cycles; TMR2 stays 0.
REQ-032 SHALL cover: a tmr2_wr_en of 0x10 in the same cycle as a match with PR2=5 -> TMR2=0x10, no pulse; TMR2 then counts to 0xFF, wraps to 0, and matches at 5.
REQ-033 SHALL cover: rst asserted the cycle of a match -> next-cycle TMR2=0, PR2=0xFF, T2CON=0, tmr2if_set=0.
REQ-034 SHALL cover: TMR2ON cleared mid-count at TMR2=7 -> TMR2 holds 7 indefinitely; after re-enable via T2CON write, counting resumes from 7 with cleared prescaler.
